// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard controller slice.
//  - Pipeline-register bit positions used to build stall/flush masks.
//  - Fence drain FSM state encoding.
//  - Helper that sizes the fence down-counter.
// No ports (package).
package hazard_ctrl_pkg;

  // Bit index of each pipeline register inside stall_o / flush_o.
  localparam int STG_IF     = 0;  // PC
  localparam int STG_IF_ID  = 1;
  localparam int STG_ID_EX  = 2;
  localparam int STG_EX_MEM = 3;

  typedef enum logic [1:0] {
    FENCE_IDLE    = 2'd0,
    FENCE_DRAIN   = 2'd1,
    FENCE_RELEASE = 2'd2
  } fence_state_e;

  // Width of a counter holding 0..fence_cycles; at least one bit so that
  // FENCE_CYCLES=0 still elaborates.
  function automatic int fence_cnt_w(input int fence_cycles);
    int w;
    w = $clog2(fence_cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: hazard requests from the pipeline stages and the
// resulting stall/flush masks plus statistics counters.
//  master : pipeline side, drives the *_i requests, receives masks/counters
//  slave  : hazard_ctrl side
// Signals:
//  wb_exception_i, mem_wait_i, ex_div_i, id_branch_flush_i, id_load_use_i,
//  id_fence_i                         hazard requests (1 bit each)
//  stall_o, flush_o    [NSTAGE-1:0]   per-register hold / bubble masks
//  fence_busy_o                       fence drain in progress
//  nr_insts_o, nr_stall_o, nr_flush_o, nr_fence_o [CNT_W-1:0]  statistics
interface hazard_ctrl_if #(
  parameter int NSTAGE = 5,
  parameter int CNT_W  = 64
);

  logic              wb_exception_i;
  logic              mem_wait_i;
  logic              ex_div_i;
  logic              id_branch_flush_i;
  logic              id_load_use_i;
  logic              id_fence_i;

  logic [NSTAGE-1:0] stall_o;
  logic [NSTAGE-1:0] flush_o;
  logic              fence_busy_o;
  logic [CNT_W-1:0]  nr_insts_o;
  logic [CNT_W-1:0]  nr_stall_o;
  logic [CNT_W-1:0]  nr_flush_o;
  logic [CNT_W-1:0]  nr_fence_o;

  modport master (
    output wb_exception_i, mem_wait_i, ex_div_i,
           id_branch_flush_i, id_load_use_i, id_fence_i,
    input  stall_o, flush_o, fence_busy_o,
           nr_insts_o, nr_stall_o, nr_flush_o, nr_fence_o
  );

  modport slave (
    input  wb_exception_i, mem_wait_i, ex_div_i,
           id_branch_flush_i, id_load_use_i, id_fence_i,
    output stall_o, flush_o, fence_busy_o,
           nr_insts_o, nr_stall_o, nr_flush_o, nr_fence_o
  );

endinterface

// File: rtl/hazard_fence_fsm.sv
// Fence drain FSM. A fence in ID is held for FENCE_CYCLES stall cycles while
// older memory traffic drains, then released exactly once.
// Ports:
//  clock, reset   clock / synchronous active-high reset
//  id_fence_i     fence instruction sitting in ID
//  row6_sel       the arbiter actually granted the fence stall this cycle
//  squash         exception or branch redirect this cycle (fence is killed)
//  if_id_stall    IF/ID register held this cycle (fence still in ID)
//  fence_stall    fence stall request to the arbiter (lowest priority)
//  fence_busy     FSM is in DRAIN
module hazard_fence_fsm
  import hazard_ctrl_pkg::*;
#(
  parameter int FENCE_CYCLES = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic id_fence_i,
  input  logic row6_sel,
  input  logic squash,
  input  logic if_id_stall,
  output logic fence_stall,
  output logic fence_busy
);

  localparam int CW = fence_cnt_w(FENCE_CYCLES);
  localparam logic FENCE_EN = (FENCE_CYCLES > 0);

  fence_state_e      state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= FENCE_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The IDLE cycle that grants the fence is its first stall cycle, so the
  // counter is loaded with the number of stall cycles still owed. DRAIN keeps
  // stalling while cnt is non-zero and only counts cycles the arbiter really
  // granted, so a higher-priority stall never eats into the fence budget.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fence_stall = 1'b0;
    unique case (state_q)
      FENCE_IDLE: begin
        fence_stall = id_fence_i && FENCE_EN;
        if (row6_sel) begin
          state_d = FENCE_DRAIN;
          cnt_d   = CW'(FENCE_CYCLES - 1);
        end
      end
      FENCE_DRAIN: begin
        fence_stall = (cnt_q != '0);
        if (cnt_q == '0) begin
          state_d = FENCE_RELEASE;
        end else if (row6_sel) begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      FENCE_RELEASE: begin
        // The same fence may still be parked in ID behind another hazard;
        // wait until it has actually moved on before re-arming.
        if (!if_id_stall) state_d = FENCE_IDLE;
      end
      default: begin
        state_d = FENCE_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (squash) begin
      state_d = FENCE_IDLE;
      cnt_d   = '0;
    end
  end

  assign fence_busy = !reset && (state_q == FENCE_DRAIN);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall/flush controller for the in-order rv64IM core.
// Prioritises hazard requests from ID/EX/MEM/WB into per-register stall and
// flush masks (bit i = pipeline register i, 0 = PC ... NSTAGE-1 = MEM/WB),
// drives the fence drain FSM and keeps retired-instruction statistics.
// Ports:
//  clock, reset   clock / synchronous active-high reset
//  hz             hazard_ctrl_if.slave: requests in, masks/counters out
// Optional build macro HAZARD_PERF_CNT_EN: when defined nr_stall_o,
// nr_flush_o and nr_fence_o count; otherwise those outputs are tied to 0.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int NSTAGE       = 5,
  parameter int FENCE_CYCLES = 3,
  parameter int CNT_W        = 64
) (
  input  logic          clock,
  input  logic          reset,
  hazard_ctrl_if.slave  hz
);

  localparam logic [NSTAGE-1:0] ONE       = NSTAGE'(1);
  localparam logic [NSTAGE-1:0] ALL       = '1;
  localparam logic [NSTAGE-1:0] STALL_ID  = (ONE << STG_IF) | (ONE << STG_IF_ID);
  localparam logic [NSTAGE-1:0] STALL_EX  = STALL_ID | (ONE << STG_ID_EX);
  // Everything up to, but not including, MEM/WB.
  localparam logic [NSTAGE-1:0] STALL_MEM = ALL >> 1;

  logic [NSTAGE-1:0] stall, flush;
  logic              row6_sel, squash;
  logic              fence_stall, fence_busy;

  hazard_fence_fsm #(
    .FENCE_CYCLES (FENCE_CYCLES)
  ) u_fence (
    .clock       (clock),
    .reset       (reset),
    .id_fence_i  (hz.id_fence_i),
    .row6_sel    (row6_sel),
    .squash      (squash),
    .if_id_stall (stall[STG_IF_ID]),
    .fence_stall (fence_stall),
    .fence_busy  (fence_busy)
  );

  // Fixed-priority arbitration; the first active request owns the cycle.
  // MEM wait and divider busy hold ID, so lower requests are simply
  // re-presented next cycle rather than remembered here.
  always_comb begin
    stall    = '0;
    flush    = '0;
    row6_sel = 1'b0;
    squash   = 1'b0;
    if (reset) begin
      flush = ALL;
    end else if (hz.wb_exception_i) begin
      flush  = ALL;
      squash = 1'b1;
    end else if (hz.mem_wait_i) begin
      stall = STALL_MEM;
      flush = ONE << (NSTAGE - 1);
    end else if (hz.ex_div_i) begin
      stall = STALL_EX;
      flush = ONE << STG_EX_MEM;
    end else if (hz.id_branch_flush_i) begin
      flush  = ONE << STG_IF_ID;
      squash = 1'b1;
    end else if (hz.id_load_use_i) begin
      stall = STALL_ID;
      flush = ONE << STG_ID_EX;
    end else if (fence_stall) begin
      stall    = STALL_ID;
      flush    = ONE << STG_ID_EX;
      row6_sel = 1'b1;
    end
  end

  assign hz.stall_o      = stall;
  assign hz.flush_o      = flush;
  assign hz.fence_busy_o = fence_busy;

  // Statistics: a cycle retires when nothing is held or bubbled. Reset
  // forces flush to all ones, so reset cycles never look clean.
  logic [CNT_W-1:0] nr_insts_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      nr_insts_q <= '0;
    end else if ((stall == '0) && (flush == '0)) begin
      nr_insts_q <= nr_insts_q + CNT_W'(1);
    end
  end

  assign hz.nr_insts_o = nr_insts_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] nr_stall_q, nr_flush_q, nr_fence_q;
  // A granted fence stall outside DRAIN can only be the IDLE->DRAIN entry,
  // since RELEASE never requests a stall.
  logic             fence_enter;

  assign fence_enter = row6_sel && !fence_busy;

  always_ff @(posedge clock) begin
    if (reset) begin
      nr_stall_q <= '0;
      nr_flush_q <= '0;
      nr_fence_q <= '0;
    end else begin
      if (stall != '0) nr_stall_q <= nr_stall_q + CNT_W'(1);
      if (flush != '0) nr_flush_q <= nr_flush_q + CNT_W'(1);
      if (fence_enter) nr_fence_q <= nr_fence_q + CNT_W'(1);
    end
  end

  assign hz.nr_stall_o = nr_stall_q;
  assign hz.nr_flush_o = nr_flush_q;
  assign hz.nr_fence_o = nr_fence_q;
`else
  assign hz.nr_stall_o = '0;
  assign hz.nr_flush_o = '0;
  assign hz.nr_fence_o = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
  localparam int NSTAGE = 5;
  localparam int FC     = 3;
  localparam int CNT_W  = 4;

  typedef struct packed {
    logic [NSTAGE-1:0] stall;
    logic [NSTAGE-1:0] flush;
    logic              busy;
    logic [CNT_W-1:0]  insts;
    logic [CNT_W-1:0]  nst;
    logic [CNT_W-1:0]  nfl;
    logic [CNT_W-1:0]  nfe;
  } exp_t;

  logic clock;
  logic reset;

  hazard_ctrl_if #(.NSTAGE(NSTAGE), .CNT_W(CNT_W)) hz ();

  hazard_ctrl #(
    .NSTAGE       (NSTAGE),
    .FENCE_CYCLES (FC),
    .CNT_W        (CNT_W)
  ) dut (
    .clock (clock),
    .reset (reset),
    .hz    (hz)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  exp_t exp_q[$];
  int   vectors   = 0;
  int   miscompares = 0;

  // Reference model state: fence phase described as "stall cycles still owed"
  // plus whether we are waiting for the fence to leave ID.
  bit               fence_open   = 0;   // a fence has been granted and is draining
  int               owed         = 0;   // fence stall cycles still to give
  bit               fence_leave  = 0;   // drain done, waiting for ID to move
  logic [CNT_W-1:0] m_insts = '0, m_nst = '0, m_nfl = '0, m_nfe = '0;

  task automatic step(input bit r, input bit e, input bit m, input bit d,
                      input bit b, input bit l, input bit f);
    exp_t x;
    bit   fence_req, granted, squash_now;
    int   st, fl;
    reset                = r;
    hz.wb_exception_i    = e;
    hz.mem_wait_i        = m;
    hz.ex_div_i          = d;
    hz.id_branch_flush_i = b;
    hz.id_load_use_i     = l;
    hz.id_fence_i        = f;

    x.insts = m_insts;
`ifdef HAZARD_PERF_CNT_EN
    x.nst = m_nst; x.nfl = m_nfl; x.nfe = m_nfe;
`else
    x.nst = '0; x.nfl = '0; x.nfe = '0;
`endif
    x.busy = !r && fence_open;

    if (!fence_open && !fence_leave) fence_req = f && (FC > 0);
    else                             fence_req = fence_open && (owed > 0);

    st = 0; fl = 0; granted = 0; squash_now = 0;
    if (r)      begin fl = (1 << NSTAGE) - 1; end
    else if (e) begin fl = (1 << NSTAGE) - 1; squash_now = 1; end
    else if (m) begin st = (1 << (NSTAGE - 1)) - 1; fl = 1 << (NSTAGE - 1); end
    else if (d) begin st = 7; fl = 8; end
    else if (b) begin fl = 2; squash_now = 1; end
    else if (l) begin st = 3; fl = 4; end
    else if (fence_req) begin st = 3; fl = 4; granted = 1; end
    x.stall = NSTAGE'(st);
    x.flush = NSTAGE'(fl);
    exp_q.push_back(x);

    if (r) begin
      fence_open = 0; fence_leave = 0; owed = 0;
      m_insts = '0; m_nst = '0; m_nfl = '0; m_nfe = '0;
    end else begin
      if (st == 0 && fl == 0) m_insts = m_insts + 1'b1;
      if (st != 0) m_nst = m_nst + 1'b1;
      if (fl != 0) m_nfl = m_nfl + 1'b1;
      if (squash_now) begin
        fence_open = 0; fence_leave = 0; owed = 0;
      end else if (fence_open) begin
        if (owed == 0) begin fence_open = 0; fence_leave = 1; end
        else if (granted) owed--;
      end else if (fence_leave) begin
        if ((st & 2) == 0) fence_leave = 0;
      end else if (granted) begin
        fence_open = 1; owed = FC - 1; m_nfe = m_nfe + 1'b1;
      end
    end
    @(posedge clock); #1;
  endtask

  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t e, a;
      e = exp_q.pop_front();
      a.stall = hz.stall_o; a.flush = hz.flush_o; a.busy = hz.fence_busy_o;
      a.insts = hz.nr_insts_o; a.nst = hz.nr_stall_o;
      a.nfl = hz.nr_flush_o;   a.nfe = hz.nr_fence_o;
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL vec%0d: got stall=%b flush=%b busy=%b insts=%0d nst=%0d nfl=%0d nfe=%0d, want stall=%b flush=%b busy=%b insts=%0d nst=%0d nfl=%0d nfe=%0d",
                 vectors, a.stall, a.flush, a.busy, a.insts, a.nst, a.nfl, a.nfe,
                 e.stall, e.flush, e.busy, e.insts, e.nst, e.nfl, e.nfe);
      end
    end
  end

  initial begin
    reset = 1'b1;
    hz.wb_exception_i = 0; hz.mem_wait_i = 0; hz.ex_div_i = 0;
    hz.id_branch_flush_i = 0; hz.id_load_use_i = 0; hz.id_fence_i = 0;
    @(posedge clock); #1;

    // reset held two cycles, then clean cycles
    step(1,0,0,0,0,0,0); step(1,0,0,0,0,0,0);
    repeat (3) step(0,0,0,0,0,0,0);
    // fence held: three stall cycles, then it leaves
    repeat (5) step(0,0,0,0,0,0,1);
    step(0,0,0,0,0,0,0); step(0,0,0,0,0,0,0);
    // divider + load-use + branch together, then branch + load-use
    step(0,0,0,1,1,1,0);
    step(0,0,0,0,1,1,0);
    // fence squashed mid-drain by a branch
    step(0,0,0,0,0,0,1); step(0,0,0,0,0,0,1);
    step(0,0,0,0,1,0,1);
    step(0,0,0,0,0,0,0);
    // exception during mem wait while draining
    step(0,0,0,0,0,0,1); step(0,0,1,0,0,0,1);
    step(0,1,1,0,0,0,1);
    step(0,0,0,0,0,0,0);
    // mem wait preempting the drain, then drain resumes
    step(0,0,0,0,0,0,1); step(0,0,1,0,0,0,1); step(0,0,0,1,0,0,1);
    repeat (4) step(0,0,0,0,0,0,1);
    step(0,0,0,0,0,0,0);
    // counter wrap: 17 clean cycles after reset
    step(1,0,0,0,0,0,0);
    repeat (17) step(0,0,0,0,0,0,0);
    step(0,0,0,0,0,0,0);

    // randomised traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0,199) == 0,
           $urandom_range(0,29) == 0,
           $urandom_range(0,7) == 0,
           $urandom_range(0,7) == 0,
           $urandom_range(0,9) == 0,
           $urandom_range(0,7) == 0,
           $urandom_range(0,2) == 0);
    end

    @(negedge clock); @(negedge clock);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
